// File: rtl/exmem_pkg.sv
// Shared types and constants for the EX->MEM elastic stage.
// The struct fixes the default field layout; payload_w() sizes other XLEN/RA_W choices.
package exmem_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned RA_W_DEF = 5;
    localparam int unsigned CTRL_W   = 8;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef struct packed {
        logic                memread;
        logic                memtoreg;
        logic                memwrite;
        logic                regwrite;
        logic                lwu;
        logic [1:0]          size;
        logic                andlink;
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] alu;
        logic [XLEN_DEF-1:0] forb;
        logic [RA_W_DEF-1:0] rd;
    } exmem_payload_t;

    localparam int unsigned PAYLOAD_W = $bits(exmem_payload_t);

    function automatic int unsigned payload_w(int unsigned xlen, int unsigned ra_w);
        return CTRL_W + 3 * xlen + ra_w;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with flush; in_ready comes straight from a flop.
// Entry M drives the output, entry S absorbs the one beat accepted while M is stalled.
module pipe_skid_buf #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         m_valid_q, m_valid_d, s_valid_q, s_valid_d, ready_q;
    logic [W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
    logic         accept, drain;

    assign accept    = in_valid & ready_q;
    assign drain     = m_valid_q & out_ready;
    assign in_ready  = ready_q;
    assign out_valid = m_valid_q;
    assign out_data  = m_data_q;

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        if (flush) begin
            // Flush beats a simultaneous accept; a drain this cycle was already taken by MEM.
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!m_valid_q) begin
            if (accept) begin
                m_valid_d = 1'b1;
                m_data_d  = in_data;
            end
        end else if (drain) begin
            if (s_valid_q) begin
                m_data_d  = s_data_q;
                s_valid_d = 1'b0;
            end else if (accept) begin
                m_data_d  = in_data;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (accept) begin
            s_valid_d = 1'b1;
            s_data_d  = in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            ready_q   <= 1'b1;
            m_data_q  <= '0;
            s_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            ready_q   <= ~s_valid_d;
            m_data_q  <= m_data_d;
            s_data_q  <= s_data_d;
        end
    end

endmodule

// File: rtl/exmem_stage_elastic.sv
// EX->MEM pipeline stage: skid-buffered payload, gated MEM controls, forwarding taps
// and a saturating stall counter.
module exmem_stage_elastic
    import exmem_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RA_W  = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_memread,
    input  logic             in_memtoreg,
    input  logic             in_memwrite,
    input  logic             in_regwrite,
    input  logic             in_lwu,
    input  logic [1:0]       in_size,
    input  logic             in_andlink,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_alu,
    input  logic [XLEN-1:0]  in_forb,
    input  logic [RA_W-1:0]  in_rd,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_memread,
    output logic             out_memtoreg,
    output logic             out_memwrite,
    output logic             out_regwrite,
    output logic             out_lwu,
    output logic [1:0]       out_size,
    output logic             out_andlink,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_alu,
    output logic [XLEN-1:0]  out_forb,
    output logic [RA_W-1:0]  out_rd,
    output logic             fwd_en,
    output logic [RA_W-1:0]  fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned PW = payload_w(XLEN, RA_W);

    logic [PW-1:0]    in_data, out_data;
    logic             m_memread, m_memwrite, m_regwrite, m_andlink;
    logic [CNT_W-1:0] stall_cnt_q;

    assign in_data = {in_memread, in_memtoreg, in_memwrite, in_regwrite, in_lwu, in_size,
                      in_andlink, in_pc, in_alu, in_forb, in_rd};

    pipe_skid_buf #(
        .W (PW)
    ) u_skid (
        .clk       (CLOCK),
        .rst       (RESET),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    assign {m_memread, out_memtoreg, m_memwrite, m_regwrite, out_lwu, out_size,
            m_andlink, out_pc, out_alu, out_forb, out_rd} = out_data;

    // Stale payload in an empty M must never trigger a side effect downstream.
    assign out_memread  = m_memread  & out_valid;
    assign out_memwrite = m_memwrite & out_valid;
    assign out_regwrite = m_regwrite & out_valid;
    assign out_andlink  = m_andlink  & out_valid;

    assign fwd_en   = out_regwrite & (out_rd != '0);
    assign fwd_rd   = out_rd;
    assign fwd_data = m_andlink ? out_pc : out_alu;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
